// File: rtl/neuron_accumulator_pkg.sv
// rtl/neuron_accumulator_pkg.sv - shared types, defaults and saturation bounds
// Purpose: FSM state encoding, default data/accumulator widths and the
//          signed saturation bounds used by the neuron accumulator.
// Ports:   none (package).
package neuron_accumulator_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest value representable in an aw-bit two's-complement word.
  function automatic longint sat_max(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in an aw-bit two's-complement word.
  function automatic longint sat_min(input int aw);
    return -(64'sd1 <<< (aw - 1));
  endfunction

endpackage

// File: rtl/neuron_accumulator_sat_add.sv
// rtl/neuron_accumulator_sat_add.sv - AW-bit signed adder with clamp
// Purpose: adds two AW-bit signed values and clamps the result to the
//          representable range, flagging when a clamp happened.
// Ports:   a, b  - signed addends
//          sum   - clamped signed sum
//          ovf   - 1 when the true sum was out of range
module sat_add
  import neuron_accumulator_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 ovf
);

  localparam logic signed [AW-1:0] HI = AW'(sat_max(AW));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(AW));

  logic [AW:0] wide;

  always_comb begin
    wide = {a[AW-1], a} + {b[AW-1], b};
    sum  = wide[AW-1:0];
    ovf  = 1'b0;
    // The two top bits of the one-bit-wider sum disagree only when the
    // true result does not fit; the extra top bit gives the true sign.
    if (wide[AW] != wide[AW-1]) begin
      ovf = 1'b1;
      sum = wide[AW] ? LO : HI;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - pipelined multiply-accumulate neuron with ReLU
// Purpose: multiplies x_in*w_in each enabled cycle, accumulates N_TERMS
//          products per frame with saturation and reports the frame sum.
// Ports:   clk       - clock, rising edge
//          rst       - asynchronous reset, active low
//          sel       - 0 = load (start frame), 1 = accumulate
//          en        - x_in/w_in carry a valid term
//          x_in,w_in - signed activation and weight
//          acc_out   - signed running / final sum
//          relu_out  - max(acc_out, 0)
//          out_valid - one-cycle pulse when a frame sum is complete
//          busy      - frame in progress
//          ovf       - sticky saturation flag for the current frame
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int AW      = AW_DEFAULT,
  parameter int N_TERMS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 en,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] w_in,
  output logic signed [AW-1:0] acc_out,
  output logic signed [AW-1:0] relu_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 ovf
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_TERMS);

  logic signed [PW-1:0] prod;
  logic                 prod_v;
  logic                 prod_sel;

  state_t               state, state_d;
  logic [CW-1:0]        count, count_d;
  logic signed [AW-1:0] acc_d, relu_d, prod_ext, sum;
  logic                 ovf_d, sum_ovf;

  // Stage 1: register the product together with its control bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod     <= '0;
      prod_v   <= 1'b0;
      prod_sel <= 1'b0;
    end else begin
      prod     <= PW'(x_in) * PW'(w_in);
      prod_v   <= en;
      prod_sel <= sel;
    end
  end

  assign prod_ext = AW'(prod);

  sat_add #(.AW(AW)) u_sat_add (
    .a   (acc_out),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // Stage 2: accumulate / load and frame sequencing.
  always_comb begin
    state_d = state;
    acc_d   = acc_out;
    count_d = count;
    ovf_d   = ovf;
    if (state == DONE) state_d = IDLE;
    if (prod_v) begin
      if (state == ACC && prod_sel) begin
        acc_d   = sum;
        count_d = count + 1'b1;
        ovf_d   = ovf | sum_ovf;
      end else begin
        // Any term outside ACC, or a sel=0 term inside it, opens a new frame.
        acc_d   = prod_ext;
        count_d = CW'(1);
        ovf_d   = 1'b0;
      end
      state_d = (count_d == LAST) ? DONE : ACC;
    end
    relu_d = acc_d[AW-1] ? '0 : acc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc_out  <= '0;
      relu_out <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_d;
      acc_out  <= acc_d;
      relu_out <= relu_d;
      count    <= count_d;
      ovf      <= ovf_d;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == ACC);

endmodule
